// File: rtl/btn_debounce_reset.sv
// Button conditioning for the board top level: 2-flop sync + debounce per button,
// one-cycle rise/fall strobes, and a btn0+btn1 hold-to-reset generator with power-on pulse.

module btn_debounce_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        db   <= ~db;
        rise <= ~db;
        fall <= db;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module btn_debounce_reset #(
  parameter int unsigned NUM_BTN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned RESET_HOLD_CYCLES  = 50_000_000,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic               cpu_resetn
);
  localparam int unsigned RMAX = (RESET_HOLD_CYCLES > RESET_PULSE_CYCLES) ?
                                 RESET_HOLD_CYCLES : RESET_PULSE_CYCLES;
  localparam int unsigned RW = (RMAX < 2) ? 1 : $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(RESET_HOLD_CYCLES - 1);
  localparam logic [RW-1:0] PULSE_LAST = RW'(RESET_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, PULSE, WAIT_RELEASE} state_t;

  state_t        state, next_state;
  logic [RW-1:0] rcnt, rcnt_next;
  logic          chord;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .db   (btn_db[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i])
    );
  end

  assign chord = btn_db[0] & btn_db[1];

  always_comb begin
    next_state = state;
    rcnt_next  = rcnt;
    case (state)
      IDLE: begin
        if (chord) begin
          next_state = HOLD;
          rcnt_next  = '0;
        end
      end
      HOLD: begin
        if (!chord) begin
          next_state = IDLE;
        end else if (rcnt == HOLD_LAST) begin
          next_state = PULSE;
          rcnt_next  = '0;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      PULSE: begin
        // Pulse width is fixed; the chord only picks where we land afterwards.
        if (rcnt == PULSE_LAST) begin
          next_state = chord ? WAIT_RELEASE : IDLE;
          rcnt_next  = '0;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!chord) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset lands in PULSE, so the power-on reset pulse falls out of the normal path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PULSE;
      rcnt       <= '0;
      cpu_resetn <= 1'b0;
    end else begin
      state      <= next_state;
      rcnt       <= rcnt_next;
      cpu_resetn <= (next_state != PULSE);
    end
  end
endmodule

// File: tb/tb_btn_debounce_reset.sv
// Directed bench: stimulus queues expected strobe/reset events with their edge number;
// a negedge monitor matches every observed event against that queue.

module tb_btn_debounce_reset;
  localparam int NB = 4, DEB = 8, HOLDC = 20, PULC = 4;
  localparam int K_RISE = 0, K_FALL = 1, K_RN_LO = 2, K_RN_HI = 3;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, btn_db, btn_rise, btn_fall;
  logic          cpu_resetn;

  btn_debounce_reset #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(HOLDC), .RESET_PULSE_CYCLES(PULC)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_db(btn_db),
    .btn_rise(btn_rise), .btn_fall(btn_fall), .cpu_resetn(cpu_resetn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0, errors = 0;
  ev_t  exp_q[$];
  logic prev_rn = 1'b0;

  function automatic void expect_ev(input int k, input int i, input int c);
    ev_t e;
    e.kind = k; e.idx = i; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic match_ev(input int k, input int i);
    int found = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (found < 0 && exp_q[j].kind == k && exp_q[j].idx == i) found = j;
    if (found < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d bit=%0d: got event at cycle %0d expected none", k, i, cyc);
    end else begin
      chk($sformatf("event_cycle kind=%0d bit=%0d", k, i), cyc, exp_q[found].cyc);
      exp_q.delete(found);
    end
  endtask

  // Monitor: every strobe and every cpu_resetn edge must be a queued expectation.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (btn_rise[i] === 1'b1) begin
        match_ev(K_RISE, i);
        chk($sformatf("db_with_rise[%0d]", i), int'(btn_db[i]), 1);
      end
      if (btn_fall[i] === 1'b1) begin
        match_ev(K_FALL, i);
        chk($sformatf("db_with_fall[%0d]", i), int'(btn_db[i]), 0);
      end
    end
    if (cpu_resetn === 1'b0 && prev_rn === 1'b1) match_ev(K_RN_LO, 0);
    if (cpu_resetn === 1'b1 && prev_rn === 1'b0) match_ev(K_RN_HI, 0);
    prev_rn = cpu_resetn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_chord_pulse(input int t);
    expect_ev(K_RN_LO, 0, t + 1 + HOLDC);
    expect_ev(K_RN_HI, 0, t + 1 + HOLDC + PULC);
  endtask

  initial begin
    int t, t2;
    reset   = 1'b1;
    btn_raw = '0;

    // Power-on
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("por_resetn", int'(cpu_resetn), 0);
      chk("por_db", int'(btn_db), 0);
      chk("por_strobes", int'(btn_rise | btn_fall), 0);
    end
    reset = 1'b0;
    expect_ev(K_RN_HI, 0, cyc + PULC);
    tick();
    chk("por_pulse_low", int'(cpu_resetn), 0);
    repeat (10) tick();

    // Clean press/release on bit 2
    btn_raw[2] = 1'b1;
    expect_ev(K_RISE, 2, cyc + 10);
    repeat (20) tick();
    chk("clean_db_high", int'(btn_db), 4'b0100);
    btn_raw[2] = 1'b0;
    expect_ev(K_FALL, 2, cyc + 10);
    repeat (20) tick();

    // Bounce on bit 3: 3-cycle segments never reach the 8-cycle window
    for (int k = 0; k < 10; k++) begin
      btn_raw[3] = (k % 2 == 0);
      repeat (3) tick();
    end
    btn_raw[3] = 1'b1;
    expect_ev(K_RISE, 3, cyc + 10);
    repeat (20) tick();
    btn_raw[3] = 1'b0;
    expect_ev(K_FALL, 3, cyc + 10);
    repeat (20) tick();

    // Chord reset, held long enough to prove no retrigger, then re-press
    for (int r = 0; r < 2; r++) begin
      btn_raw[1:0] = 2'b11;
      t = cyc + 10;
      expect_ev(K_RISE, 0, t);
      expect_ev(K_RISE, 1, t);
      expect_chord_pulse(t);
      repeat (60) tick();
      chk("chord_held_resetn", int'(cpu_resetn), 1);
      btn_raw[1:0] = 2'b00;
      expect_ev(K_FALL, 0, cyc + 10);
      expect_ev(K_FALL, 1, cyc + 10);
      repeat (20) tick();
    end

    // Aborted chord: drop after 15 debounced cycles, then a full hold is needed
    btn_raw[1:0] = 2'b11;
    t = cyc + 10;
    expect_ev(K_RISE, 0, t);
    expect_ev(K_RISE, 1, t);
    repeat (15) tick();
    btn_raw[1] = 1'b0;
    expect_ev(K_FALL, 1, t + 15);
    repeat (15) tick();
    chk("abort_resetn", int'(cpu_resetn), 1);
    btn_raw[1] = 1'b1;
    t2 = cyc + 10;
    expect_ev(K_RISE, 1, t2);
    expect_chord_pulse(t2);
    repeat (40) tick();
    btn_raw[1:0] = 2'b00;
    expect_ev(K_FALL, 0, cyc + 10);
    expect_ev(K_FALL, 1, cyc + 10);
    repeat (20) tick();

    // Mid-operation reset while HOLD has rcnt=10
    btn_raw[1:0] = 2'b11;
    t = cyc + 10;
    expect_ev(K_RISE, 0, t);
    expect_ev(K_RISE, 1, t);
    repeat (21) tick();
    chk("mid_db_chord", int'(btn_db), 4'b0011);
    chk("mid_resetn_pre", int'(cpu_resetn), 1);
    reset   = 1'b1;
    btn_raw = '0;
    expect_ev(K_RN_LO, 0, cyc + 1);
    repeat (3) tick();
    chk("mid_db_cleared", int'(btn_db), 0);
    chk("mid_resetn_low", int'(cpu_resetn), 0);
    reset = 1'b0;
    expect_ev(K_RN_HI, 0, cyc + PULC);
    repeat (20) tick();

    chk("pending_events", exp_q.size(), 0);
    foreach (exp_q[j])
      $display("FAIL missing_event kind=%0d bit=%0d: got nothing expected at cycle %0d",
               exp_q[j].kind, exp_q[j].idx, exp_q[j].cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
